// File: rtl/perm_seq_ctrl.sv
// ============================================================================
// perm_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencer / controller for the 4-bit permutation-walk state register.
// The block owns the state register and decides when it steps. The next
// value is looked up by an external combinational table: we drive cur_state
// out and take next_in back in the same cycle.
//
// Operations:
//   single-step : one step per step_btn press (IDLE only)
//   free-run    : run_btn toggles RUN; in RUN a step happens every period+1
//                 clock cycles (optionally stopping when the walk returns to
//                 INIT)
//   clear       : clr_btn returns the state to INIT and zeroes the step count
//
// The cycle length of the permutation (steps taken from INIT back to INIT)
// is latched into cycle_len for display on the seven-segment digits.
//
// Ports:
//   hz100       in   system clock, the only clock
//   reset       in   synchronous active-high reset, beats every other input
//   step_btn    in   raw pushbutton, request one step
//   run_btn     in   raw pushbutton, toggle RUN / IDLE
//   clr_btn     in   raw pushbutton, clear state and step count
//   period      in   run-mode step interval minus 1, in clock cycles
//   next_in     in   table output for the value currently on cur_state
//   cur_state   out  current state register
//   running     out  registered "FSM is in RUN"
//   step_pulse  out  high in the cycle a step is committed
//   step_count  out  steps since last clear/reset, saturating at 31
//   cycle_len   out  step count latched at the last return to INIT (0 = none)
//   cycle_done  out  high in the cycle a committed step lands on INIT
// ============================================================================
module perm_seq_ctrl #(
    parameter int           W             = 4,
    parameter logic [W-1:0] INIT          = '0,
    parameter int           DIV_W         = 7,
    parameter bit           STOP_ON_CYCLE = 1'b1
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             clr_btn,
    input  logic [DIV_W-1:0] period,
    input  logic [W-1:0]     next_in,
    output logic [W-1:0]     cur_state,
    output logic             running,
    output logic             step_pulse,
    output logic [4:0]       step_count,
    output logic [4:0]       cycle_len,
    output logic             cycle_done
);

    // ------------------------------------------------------------------------
    // Types and state
    // ------------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsmState_e;

    // Bit positions of the three buttons inside the packed button vectors.
    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_CLR  = 2;

    localparam logic [4:0] COUNT_MAX = 5'd31;

    fsmState_e        fsm_q, fsm_d;
    logic [W-1:0]     curState_q, curState_d;
    logic [4:0]       stepCount_q, stepCount_d;
    logic [4:0]       cycleLen_q, cycleLen_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             running_q;

    // Button conditioning registers, one bit per button.
    logic [2:0] btnRaw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] prev_q;
    logic [2:0] armed_q;
    logic [1:0] warm_q;
    logic [2:0] btnEvent;

    // Internal decode of the conditioned buttons and the commit condition.
    logic       stepEv;
    logic       runEv;
    logic       clrEv;
    logic       commit;
    logic       landsOnInit;
    logic [4:0] stepCountInc;

    assign btnRaw = {clr_btn, run_btn, step_btn};

    // ------------------------------------------------------------------------
    // Button synchronizers and rising-edge detectors.
    // Each raw button goes through two flops before it is trusted, then a
    // third flop remembers the previous synchronized level so a rising edge
    // shows up as a single-cycle event on the third clock after the press.
    // Holding the button keeps sync2 high, so only one event is produced.
    //
    // The armed bit stops a button that was already held when reset released
    // from looking like a fresh press: the synchronizer restarts from 0, so
    // without it the first real sample of a held button would read as an
    // edge. warm_q tracks when sync2 has started reflecting the real pin; a
    // button is armed only once it has been seen low after that point.
    // ------------------------------------------------------------------------
    always_ff @(posedge hz100) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= btnRaw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            warm_q  <= {warm_q[0], 1'b1};
            if (warm_q[1]) begin
                armed_q <= armed_q | ~sync2_q;
            end
        end
    end

    assign btnEvent = sync2_q & ~prev_q & armed_q;
    assign stepEv   = btnEvent[BTN_STEP];
    assign runEv    = btnEvent[BTN_RUN];
    assign clrEv    = btnEvent[BTN_CLR];

    // Saturating increment shared by step_count and the cycle_len latch, and
    // the "this step closes the cycle" test on the table output.
    assign stepCountInc = (stepCount_q == COUNT_MAX) ? COUNT_MAX
                                                     : stepCount_q + 5'd1;
    assign landsOnInit  = (next_in == INIT);

    // ------------------------------------------------------------------------
    // Next-state logic for the sequencer FSM and its datapath.
    // Priority, highest first: reset (handled in the register block and by
    // masking commit here), clear, then the per-state behaviour. In IDLE the
    // run button beats the step button. In RUN the run button beats a
    // coincident prescaler hit so stopping never sneaks in an extra step.
    // The prescaler compare uses >= so a period lowered mid-run below the
    // current count still fires at the next compare instead of wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        fsm_d       = fsm_q;
        curState_d  = curState_q;
        stepCount_d = stepCount_q;
        cycleLen_d  = cycleLen_q;
        presc_d     = presc_q;
        commit      = 1'b0;

        if (reset) begin
            commit = 1'b0;
        end else if (clrEv) begin
            fsm_d       = IDLE;
            curState_d  = INIT;
            stepCount_d = '0;
            presc_d     = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    presc_d = '0;
                    if (runEv) begin
                        fsm_d = RUN;
                    end else if (stepEv) begin
                        commit = 1'b1;
                    end
                end
                RUN: begin
                    if (runEv) begin
                        fsm_d   = IDLE;
                        presc_d = '0;
                    end else if (presc_q >= period) begin
                        commit  = 1'b1;
                        presc_d = '0;
                        if (STOP_ON_CYCLE && landsOnInit) begin
                            fsm_d = IDLE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    fsm_d   = IDLE;
                    presc_d = '0;
                end
            endcase
        end

        if (commit) begin
            curState_d  = next_in;
            stepCount_d = stepCountInc;
            if (landsOnInit) begin
                cycleLen_d = stepCountInc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers. running is registered from the next FSM state so it
    // always matches the FSM register without a cycle of lag.
    // ------------------------------------------------------------------------
    always_ff @(posedge hz100) begin
        if (reset) begin
            fsm_q       <= IDLE;
            curState_q  <= INIT;
            stepCount_q <= '0;
            cycleLen_q  <= '0;
            presc_q     <= '0;
            running_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            curState_q  <= curState_d;
            stepCount_q <= stepCount_d;
            cycleLen_q  <= cycleLen_d;
            presc_q     <= presc_d;
            running_q   <= (fsm_d == RUN);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The pulses come straight from the commit condition, which is
    // already forced low during reset and clear.
    // ------------------------------------------------------------------------
    assign cur_state  = curState_q;
    assign running    = running_q;
    assign step_count = stepCount_q;
    assign cycle_len  = cycleLen_q;
    assign step_pulse = commit;
    assign cycle_done = commit & landsOnInit;

endmodule
